regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised integer register file with a per-register scoreboard for the next-generation pipeline.
- Each register carries a busy bit and a producer tag.
- ID reserves destinations at issue; MEM_WB writebacks retire them; flush clears all reservations.
- Storage is non-reset RAM-style. A post-reset init sweep zeroes it before the block accepts traffic.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; DEPTH = 2**ADDR_W entries.
- TAG_W, 4, producer tag width.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- init_done  out  1  high once the clearing sweep completes.
- rsv_flag  in  1  reserve destination this cycle.
- rsv_addr  in  ADDR_W  destination register to reserve.
- rsv_tag  in  TAG_W  producer tag recorded for rsv_addr.
- wb_flag  in  1  writeback valid (from MEM_WB).
- wb_addr  in  ADDR_W  writeback register.
- wb_tag  in  TAG_W  tag of the writing producer.
- wb_data  in  DATA_W  writeback data.
- flush  in  1  clear all busy bits.
- rd1_flag, rd2_flag  in  1  read port enables (from ID).
- rd1_addr, rd2_addr  in  ADDR_W  read indices.
- rd1_data, rd2_data  out  DATA_W  read data (combinational).
- rd1_ready, rd2_ready  out  1  operand valid; low means wait on tag.
- rd1_tag, rd2_tag  out  TAG_W  pending producer tag when not ready.

Behaviour:
- Reset (rst low, async):
  - FSM enters INIT; sweep counter = 0; init_done = 0.
  - All busy bits = 0; all stored tags = 0.
- INIT state:
  - One entry is written with 0 per cycle at the counter index.
  - The counter increments, wrapping from DEPTH-1 to 0; sweep completes after exactly DEPTH cycles.
  - FSM moves to RUN and init_done = 1 on the edge that writes entry DEPTH-1.
  - rsv, wb and flush are ignored during INIT.
  - All read outputs are 0 (data, ready, tag).
- RUN state is terminal until the next reset. A reset mid-sweep or mid-run restarts INIT from counter 0.
- Register 0:
  - Hardwired zero; never busy; writes and reservations to it are discarded.
  - Reads of it return data 0, ready 1, tag 0.
- Writeback, at the edge when wb_flag=1 and wb_addr!=0:
  - regs[wb_addr] <= wb_data unconditionally.
  - busy[wb_addr] is cleared only if busy=1 and tag[wb_addr]==wb_tag. A stale writeback does not release a younger reservation.
- Reservation, at the edge when rsv_flag=1 and rsv_addr!=0:
  - busy <= 1 and tag <= rsv_tag, overwriting any existing reservation.
- Flush: at the edge all busy bits clear, and stored tags may keep their values.
- Simultaneous events on the same edge:
  - rsv and wb to the same register: data is written, and the reservation wins (busy=1, new tag).
  - flush and rsv: flush applies first, then rsv, so the new reservation survives.
  - flush and wb: the data write still occurs.
- Read port (identical per port, purely combinational, zero latency):
  - If not init_done or flag=0: data 0, ready 0, tag 0.
  - Else if addr==0: data 0, ready 1, tag 0.
  - Else if bypass hits (see Optional Feature): data = wb_data, ready 1, tag 0.
  - Else: data = regs[addr], ready = !busy[addr], tag = busy ? tag[addr] : 0.
- Same-cycle reservations are not visible to reads; they take effect from the next cycle.

Optional Feature:
- Macro REGFILE_WB_BYPASS_EN.
- Defined:
  - A read bypasses when wb_flag=1, wb_addr==addr!=0, and either busy[addr]=0 or tag[addr]==wb_tag.
  - Same-cycle writeback data is forwarded with ready=1.
- Undefined:
  - No forwarding; reads show stored state only.
  - The consumer sees ready=1 and the new data one cycle after the writeback edge.

Test Plan:
- Init sweep: drop rst for 2 cycles, release, DEPTH=32 -> init_done rises exactly 32 cycles after release. Reads of all 32 registers then return 0 with ready=1. A wb issued during INIT has no effect.
- Reservation lifecycle:
  - rsv x5 tag 3 -> next cycle rd1 x5 gives ready=0, tag=3.
  - wb x5 tag 3 data 0xDEADBEEF -> same cycle (bypass on) ready=1, data 0xDEADBEEF.
  - Next cycle: ready=1 from storage.
- Stale writeback: rsv x7 tag 1, then rsv x7 tag 2, then wb x7 tag 1 data 0x11 -> x7 stays busy with tag 2 and holds 0x11. A later wb tag 2 data 0x22 -> ready=1, data 0x22.
- Simultaneous events:
  - Same edge rsv x9 tag 4 + wb x9 tag 0 data 0x55 -> x9 busy, tag 4, holds 0x55.
  - Same edge flush + rsv x10 tag 6 -> x10 busy (tag 6); all other registers ready.
- x0 handling: rsv x0 and wb x0 data 0xFFFFFFFF -> rd x0 returns data 0, ready 1; rd_flag=0 returns 0 and ready=0.
- Async reset mid-run: assert rst low between edges while x3 is busy -> init_done falls immediately. After release, the sweep repeats and x3 reads as 0 and ready.

Source files
------------

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: pipeline-side bundle for the scoreboarded register file.
// master = ID/MEM_WB stages, slave = the register file itself.
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int TAG_W  = 4
);
  logic              init_done;

  // Handshake: each *_flag qualifies its address/tag/data fields for exactly one
  // rising edge. The register file never stalls a flag, so there is no back-pressure.
  // Reads are combinational: rdN_ready=1 means rdN_data is a valid operand this
  // cycle. rdN_ready=0 means the consumer waits for the producer named by rdN_tag.
  logic              rsv_flag;
  logic [ADDR_W-1:0] rsv_addr;
  logic [TAG_W-1:0]  rsv_tag;

  logic              wb_flag;
  logic [ADDR_W-1:0] wb_addr;
  logic [TAG_W-1:0]  wb_tag;
  logic [DATA_W-1:0] wb_data;

  logic              flush;

  logic              rd1_flag;
  logic [ADDR_W-1:0] rd1_addr;
  logic [DATA_W-1:0] rd1_data;
  logic              rd1_ready;
  logic [TAG_W-1:0]  rd1_tag;

  logic              rd2_flag;
  logic [ADDR_W-1:0] rd2_addr;
  logic [DATA_W-1:0] rd2_data;
  logic              rd2_ready;
  logic [TAG_W-1:0]  rd2_tag;

  modport master (
    input  init_done,
    output rsv_flag, rsv_addr, rsv_tag,
    output wb_flag, wb_addr, wb_tag, wb_data,
    output flush,
    output rd1_flag, rd1_addr,
    input  rd1_data, rd1_ready, rd1_tag,
    output rd2_flag, rd2_addr,
    input  rd2_data, rd2_ready, rd2_tag
  );

  modport slave (
    output init_done,
    input  rsv_flag, rsv_addr, rsv_tag,
    input  wb_flag, wb_addr, wb_tag, wb_data,
    input  flush,
    input  rd1_flag, rd1_addr,
    output rd1_data, rd1_ready, rd1_tag,
    input  rd2_flag, rd2_addr,
    output rd2_data, rd2_ready, rd2_tag
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with per-register busy/tag scoreboard and a post-reset zeroing sweep.
// Optional same-cycle writeback forwarding to the read ports is enabled by defining REGFILE_WB_BYPASS_EN.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int TAG_W  = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        dbg_state_o,
  regfile_sb_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e                        state_q, state_d;
  logic [ADDR_W-1:0]             cnt_q, cnt_d;
  logic [DEPTH-1:0]              busy_q, busy_d;
  logic [DEPTH-1:0][TAG_W-1:0]   tag_q, tag_d;
  logic [DATA_W-1:0]             regs_q [DEPTH];

  logic                          sweep_we;
  logic                          wb_we;
  logic                          wb_live;
  logic                          rsv_live;
  logic                          init_done;

  assign wb_live     = bus.wb_flag && (bus.wb_addr != '0);
  assign rsv_live    = bus.rsv_flag && (bus.rsv_addr != '0);
  assign init_done   = (state_q == S_RUN);
  assign dbg_state_o = logic'(state_q);
  assign bus.init_done = init_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      busy_q  <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      tag_q   <= tag_d;
    end
  end

  // Order inside RUN matters: flush, then tag-matched release, then reservation,
  // so a same-edge reservation always survives both.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    tag_d    = tag_q;
    sweep_we = 1'b0;
    wb_we    = 1'b0;
    case (state_q)
      S_INIT: begin
        sweep_we = 1'b1;
        cnt_d    = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        wb_we = wb_live;
        if (bus.flush) begin
          busy_d = '0;
        end
        if (wb_live && busy_q[bus.wb_addr] && (tag_q[bus.wb_addr] == bus.wb_tag)) begin
          busy_d[bus.wb_addr] = 1'b0;
        end
        if (rsv_live) begin
          busy_d[bus.rsv_addr] = 1'b1;
          tag_d[bus.rsv_addr]  = bus.rsv_tag;
        end
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Storage has no reset; the INIT sweep is what makes its contents defined.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      regs_q[cnt_q] <= '0;
    end else if (wb_we) begin
      regs_q[bus.wb_addr] <= bus.wb_data;
    end
  end

  logic [1:0]                    rd_flag;
  logic [1:0][ADDR_W-1:0]        rd_addr;
  logic [1:0]                    rd_byp;
  logic [1:0][DATA_W-1:0]        rd_data;
  logic [1:0]                    rd_ready;
  logic [1:0][TAG_W-1:0]         rd_tag;

  assign rd_flag = {bus.rd2_flag, bus.rd1_flag};
  assign rd_addr = {bus.rd2_addr, bus.rd1_addr};

`ifdef REGFILE_WB_BYPASS_EN
  // Forward only a writeback that will actually satisfy the stored state:
  // a stale tag against a live reservation must not look ready.
  always_comb begin
    rd_byp = '0;
    for (int p = 0; p < 2; p++) begin
      rd_byp[p] = wb_live && (bus.wb_addr == rd_addr[p]) &&
                  (!busy_q[rd_addr[p]] || (tag_q[rd_addr[p]] == bus.wb_tag));
    end
  end
`else
  assign rd_byp = '0;
`endif

  always_comb begin
    rd_data  = '0;
    rd_ready = '0;
    rd_tag   = '0;
    for (int p = 0; p < 2; p++) begin
      if (init_done && rd_flag[p]) begin
        if (rd_addr[p] == '0) begin
          rd_ready[p] = 1'b1;
        end else if (rd_byp[p]) begin
          rd_data[p]  = bus.wb_data;
          rd_ready[p] = 1'b1;
        end else begin
          rd_data[p]  = regs_q[rd_addr[p]];
          rd_ready[p] = !busy_q[rd_addr[p]];
          rd_tag[p]   = busy_q[rd_addr[p]] ? tag_q[rd_addr[p]] : '0;
        end
      end
    end
  end

  assign bus.rd1_data  = rd_data[0];
  assign bus.rd1_ready = rd_ready[0];
  assign bus.rd1_tag   = rd_tag[0];
  assign bus.rd2_data  = rd_data[1];
  assign bus.rd2_ready = rd_ready[1];
  assign bus.rd2_tag   = rd_tag[1];
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and random checks of regfile_sb against a behavioural scoreboard model.
module tb_regfile_sb;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int TAG_W  = 4;
  localparam int DEPTH  = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic dbg_state;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W)) bus ();

  regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .dbg_state_o (dbg_state),
    .bus         (bus)
  );

  // Reference model: architectural view of the register file.
  logic [DATA_W-1:0] m_regs [DEPTH];
  bit                m_busy [DEPTH];
  logic [TAG_W-1:0]  m_tag  [DEPTH];
  bit                m_done;
  int                m_cnt;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_done = 1'b0;
    m_cnt  = 0;
    for (int i = 0; i < DEPTH; i++) begin
      m_busy[i] = 1'b0;
      m_tag[i]  = '0;
    end
  endtask

  function automatic void model_read(input logic flag, input logic [ADDR_W-1:0] a,
                                     output logic [DATA_W-1:0] d, output logic r,
                                     output logic [TAG_W-1:0] t);
    d = '0;
    r = 1'b0;
    t = '0;
    if (!m_done || !flag) return;
    if (a == '0) begin
      r = 1'b1;
      return;
    end
`ifdef REGFILE_WB_BYPASS_EN
    if (bus.wb_flag && bus.wb_addr == a && (!m_busy[a] || m_tag[a] == bus.wb_tag)) begin
      d = bus.wb_data;
      r = 1'b1;
      return;
    end
`endif
    d = m_regs[a];
    r = !m_busy[a];
    t = m_busy[a] ? m_tag[a] : '0;
  endfunction

  // Applies the inputs that were present at the edge just taken.
  task automatic model_edge();
    bit clr;
    if (!rst) begin
      model_reset();
      return;
    end
    if (!m_done) begin
      m_cnt++;
      if (m_cnt == DEPTH) begin
        m_done = 1'b1;
        for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
      end
      return;
    end
    clr = bus.wb_flag && bus.wb_addr != '0 && m_busy[bus.wb_addr] && m_tag[bus.wb_addr] == bus.wb_tag;
    if (bus.wb_flag && bus.wb_addr != '0) m_regs[bus.wb_addr] = bus.wb_data;
    if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
    end
    if (clr) m_busy[bus.wb_addr] = 1'b0;
    if (bus.rsv_flag && bus.rsv_addr != '0) begin
      m_busy[bus.rsv_addr] = 1'b1;
      m_tag[bus.rsv_addr]  = bus.rsv_tag;
    end
  endtask

  task automatic check_outputs();
    logic [DATA_W-1:0] d;
    logic              r;
    logic [TAG_W-1:0]  t;
    check("init_done", 64'(bus.init_done), 64'(m_done));
    check("dbg_state", 64'(dbg_state), 64'(m_done));
    model_read(bus.rd1_flag, bus.rd1_addr, d, r, t);
    check("rd1_data", 64'(bus.rd1_data), 64'(d));
    check("rd1_ready", 64'(bus.rd1_ready), 64'(r));
    check("rd1_tag", 64'(bus.rd1_tag), 64'(t));
    model_read(bus.rd2_flag, bus.rd2_addr, d, r, t);
    check("rd2_data", 64'(bus.rd2_data), 64'(d));
    check("rd2_ready", 64'(bus.rd2_ready), 64'(r));
    check("rd2_tag", 64'(bus.rd2_tag), 64'(t));
  endtask

  // Entered at a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.rsv_flag = 1'b0; bus.rsv_addr = '0; bus.rsv_tag = '0;
    bus.wb_flag  = 1'b0; bus.wb_addr  = '0; bus.wb_tag  = '0; bus.wb_data = '0;
    bus.flush    = 1'b0;
    bus.rd1_flag = 1'b1; bus.rd1_addr = '0;
    bus.rd2_flag = 1'b1; bus.rd2_addr = '0;
  endtask

  task automatic rd1(input int a);
    bus.rd1_flag = 1'b1;
    bus.rd1_addr = ADDR_W'(a);
  endtask

  task automatic run_init(input string name);
    int n;
    n = 0;
    for (int i = 1; i <= DEPTH + 8; i++) begin
      cycle();
      n = i;
      if (bus.init_done) break;
    end
    if (!bus.init_done) n = DEPTH + 9;
    check(name, 64'(n), 64'(DEPTH));
  endtask

  initial begin
    idle();
    model_reset();
    rst = 1'b0;
    @(negedge clk);
    cycle();
    cycle();
    rst = 1'b1;

    // Sweep, with a writeback and reads attempted while it runs.
    bus.wb_flag = 1'b1; bus.wb_addr = 5'd4; bus.wb_data = 32'h1234; bus.wb_tag = '0;
    rd1(4);
    run_init("init_latency");
    idle();

    for (int a = 0; a < DEPTH; a++) begin
      rd1(a);
      bus.rd2_addr = ADDR_W'(DEPTH - 1 - a);
      #1;
      check("post_init_data", 64'(bus.rd1_data), 64'h0);
      check("post_init_ready", 64'(bus.rd1_ready), 64'h1);
      cycle();
    end
    idle();

    // Reservation lifecycle on x5.
    bus.rsv_flag = 1'b1; bus.rsv_addr = 5'd5; bus.rsv_tag = 4'd3; rd1(5);
    cycle();
    idle(); rd1(5);
    #1;
    check("rsv_x5_ready", 64'(bus.rd1_ready), 64'h0);
    check("rsv_x5_tag", 64'(bus.rd1_tag), 64'h3);
    cycle();
    bus.wb_flag = 1'b1; bus.wb_addr = 5'd5; bus.wb_tag = 4'd3; bus.wb_data = 32'hDEADBEEF; rd1(5);
    #1;
`ifdef REGFILE_WB_BYPASS_EN
    check("byp_x5_ready", 64'(bus.rd1_ready), 64'h1);
    check("byp_x5_data", 64'(bus.rd1_data), 64'hDEADBEEF);
`else
    check("nobyp_x5_ready", 64'(bus.rd1_ready), 64'h0);
`endif
    cycle();
    idle(); rd1(5);
    #1;
    check("wb_x5_ready", 64'(bus.rd1_ready), 64'h1);
    check("wb_x5_data", 64'(bus.rd1_data), 64'hDEADBEEF);
    cycle();

    // Stale writeback must not release the younger reservation.
    idle(); bus.rsv_flag = 1'b1; bus.rsv_addr = 5'd7; bus.rsv_tag = 4'd1; rd1(7);
    cycle();
    bus.rsv_tag = 4'd2;
    cycle();
    idle(); bus.wb_flag = 1'b1; bus.wb_addr = 5'd7; bus.wb_tag = 4'd1; bus.wb_data = 32'h11; rd1(7);
    cycle();
    idle(); rd1(7);
    #1;
    check("stale_x7_ready", 64'(bus.rd1_ready), 64'h0);
    check("stale_x7_tag", 64'(bus.rd1_tag), 64'h2);
    check("stale_x7_data", 64'(bus.rd1_data), 64'h11);
    cycle();
    bus.wb_flag = 1'b1; bus.wb_addr = 5'd7; bus.wb_tag = 4'd2; bus.wb_data = 32'h22;
    cycle();
    idle(); rd1(7);
    #1;
    check("final_x7_ready", 64'(bus.rd1_ready), 64'h1);
    check("final_x7_data", 64'(bus.rd1_data), 64'h22);
    cycle();

    // Same-edge reservation and writeback to x9.
    idle();
    bus.rsv_flag = 1'b1; bus.rsv_addr = 5'd9; bus.rsv_tag = 4'd4;
    bus.wb_flag = 1'b1; bus.wb_addr = 5'd9; bus.wb_tag = 4'd0; bus.wb_data = 32'h55;
    cycle();
    idle(); rd1(9);
    #1;
    check("rsvwb_x9_ready", 64'(bus.rd1_ready), 64'h0);
    check("rsvwb_x9_tag", 64'(bus.rd1_tag), 64'h4);
    check("rsvwb_x9_data", 64'(bus.rd1_data), 64'h55);
    cycle();

    // Same-edge flush and reservation to x10, then scan everything.
    idle(); bus.flush = 1'b1; bus.rsv_flag = 1'b1; bus.rsv_addr = 5'd10; bus.rsv_tag = 4'd6;
    cycle();
    idle();
    for (int a = 0; a < DEPTH; a++) begin
      rd1(10);
      bus.rd2_addr = ADDR_W'(a);
      #1;
      check("flush_x10_tag", 64'(bus.rd1_tag), 64'h6);
      if (a != 10) check("flush_other_ready", 64'(bus.rd2_ready), 64'h1);
      cycle();
    end

    // x0 is hardwired.
    idle();
    bus.rsv_flag = 1'b1; bus.rsv_addr = '0; bus.rsv_tag = 4'd5;
    bus.wb_flag = 1'b1; bus.wb_addr = '0; bus.wb_data = 32'hFFFFFFFF; bus.wb_tag = 4'd5;
    cycle();
    idle(); rd1(0); bus.rd2_flag = 1'b0; bus.rd2_addr = '0;
    #1;
    check("x0_data", 64'(bus.rd1_data), 64'h0);
    check("x0_ready", 64'(bus.rd1_ready), 64'h1);
    check("x0_tag", 64'(bus.rd1_tag), 64'h0);
    check("rd2_off_ready", 64'(bus.rd2_ready), 64'h0);
    check("rd2_off_data", 64'(bus.rd2_data), 64'h0);
    cycle();

    // Random traffic concentrated on a few registers to force collisions.
    for (int i = 0; i < 400; i++) begin
      bus.rsv_flag = 1'($urandom_range(0, 1));
      bus.rsv_addr = ADDR_W'($urandom_range(0, 7));
      bus.rsv_tag  = TAG_W'($urandom_range(0, 3));
      bus.wb_flag  = 1'($urandom_range(0, 1));
      bus.wb_addr  = ADDR_W'($urandom_range(0, 7));
      bus.wb_tag   = TAG_W'($urandom_range(0, 3));
      bus.wb_data  = DATA_W'($urandom);
      bus.flush    = ($urandom_range(0, 15) == 0);
      bus.rd1_flag = ($urandom_range(0, 7) != 0);
      bus.rd1_addr = ADDR_W'($urandom_range(0, 7));
      bus.rd2_flag = ($urandom_range(0, 7) != 0);
      bus.rd2_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      cycle();
    end

    // Async reset between edges while x3 is busy.
    idle(); bus.rsv_flag = 1'b1; bus.rsv_addr = 5'd3; bus.rsv_tag = 4'd9;
    cycle();
    idle(); rd1(3);
    #1;
    check("x3_busy_before_rst", 64'(bus.rd1_ready), 64'h0);
    #1;
    rst = 1'b0;
    #1;
    check("async_init_done", 64'(bus.init_done), 64'h0);
    check("async_rd1_ready", 64'(bus.rd1_ready), 64'h0);
    model_reset();
    @(negedge clk);
    cycle();
    cycle();
    rst = 1'b1;
    run_init("reinit_latency");
    idle(); rd1(3);
    #1;
    check("x3_after_rst_data", 64'(bus.rd1_data), 64'h0);
    check("x3_after_rst_ready", 64'(bus.rd1_ready), 64'h1);
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
